// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: refill FSM states and
// helpers that derive the address-field widths from the cache geometry.
package icache_pkg;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } ic_state_e;

  // Bits selecting a word inside a line (WORD_BITS).
  function automatic int ic_word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  // Bits selecting a set (INDEX_BITS).
  function automatic int ic_index_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Remaining upper address bits stored as the tag (TAG_BITS).
  function automatic int ic_tag_bits(input int addr_w, input int line_words, input int sets);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: holds the captured line base, walks the beat
// counter, drives the word-wide memory request and emits array write strobes.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int ADDR_W     = 32,
  localparam int WORD_BITS  = ic_word_bits(LINE_WORDS),
  localparam int INDEX_BITS = ic_index_bits(SETS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  busy_o,
  output logic                  wr_en_o,
  output logic                  last_o,
  output logic [WORD_BITS-1:0]  beat_o,
  output logic [INDEX_BITS-1:0] idx_o
);

  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

  ic_state_e             state_q, state_d;
  logic [WORD_BITS-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0]     base_q, base_d;

  // State, beat counter and captured base; reset abandons any refill.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IC_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic: one beat per accepted memory word, exit on the last.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    wr_en_o = 1'b0;
    last_o  = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (start_i) begin
          base_d  = base_i;
          beat_d  = '0;
          state_d = IC_FILL;
        end
      end
      IC_FILL: begin
        if (mem_rvalid_i) begin
          wr_en_o = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            last_o  = 1'b1;
            state_d = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  // Request and address depend only on registers, so they stay stable
  // across memory wait cycles.
  assign busy_o     = (state_q == IC_FILL);
  assign mem_req_o  = busy_o;
  assign mem_addr_o = busy_o ? (base_q + ADDR_W'({beat_q, 2'b00})) : '0;
  assign beat_o     = beat_q;
  assign idx_o      = base_q[2+WORD_BITS +: INDEX_BITS];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: flop storage, combinational
// lookup, registered instruction output and hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_hold,
  input  logic              ic_clear,
  output logic [31:0]       ic_rdata,
  output logic              ICacheMiss,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int WORD_BITS  = ic_word_bits(LINE_WORDS);
  localparam int INDEX_BITS = ic_index_bits(SETS);
  localparam int TAG_BITS   = ic_tag_bits(ADDR_W, LINE_WORDS, SETS);

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [31:0]         data_q [SETS][LINE_WORDS];

  logic [31:0]         rdata_q;
  logic [31:0]         hit_cnt_q;
  logic [31:0]         miss_cnt_q;

  logic [WORD_BITS-1:0]  lookup_word;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [ADDR_W-1:0]     line_base;
  logic                  hit;
  logic                  miss_start;

  logic                  fill_busy;
  logic                  fill_wr;
  logic                  fill_last;
  logic [WORD_BITS-1:0]  fill_beat;
  logic [INDEX_BITS-1:0] fill_idx;

  // Byte offset within a word never matters for a word fetch.
  logic unused_offset;
  assign unused_offset = ^ic_addr[1:0];

  assign lookup_word = ic_addr[2 +: WORD_BITS];
  assign lookup_idx  = ic_addr[2+WORD_BITS +: INDEX_BITS];
  assign lookup_tag  = ic_addr[ADDR_W-1 -: TAG_BITS];
  assign line_base   = {ic_addr[ADDR_W-1:2+WORD_BITS], {(WORD_BITS+2){1'b0}}};

  assign hit        = ic_req & valid_q[lookup_idx] & (tag_q[lookup_idx] == lookup_tag);
  // A new refill can only start from IDLE, so there is always an IDLE
  // cycle between back-to-back refills.
  assign miss_start = ~fill_busy & ic_req & ~hit;
  assign ICacheMiss = fill_busy | miss_start;

  icache_refill_fsm #(
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS),
    .ADDR_W     (ADDR_W)
  ) u_refill (
    .clk_i        (CPU_CLK),
    .rst_ni       (CPU_RST_N),
    .start_i      (miss_start),
    .base_i       (line_base),
    .mem_rvalid_i (mem_rvalid),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .busy_o       (fill_busy),
    .wr_en_o      (fill_wr),
    .last_o       (fill_last),
    .beat_o       (fill_beat),
    .idx_o        (fill_idx)
  );

  // Valid bits: invalidate the victim when its refill starts, mark it valid
  // only after the final beat so a reset mid-refill leaves it invalid.
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      valid_q <= '0;
    end else if (miss_start) begin
      valid_q[lookup_idx] <= 1'b0;
    end else if (fill_last) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge CPU_CLK) begin
    if (miss_start) begin
      tag_q[lookup_idx] <= lookup_tag;
    end
    if (fill_wr) begin
      data_q[fill_idx][fill_beat] <= mem_rdata;
    end
  end

  // Instruction register for ID: clear beats hold beats a fresh hit.
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      rdata_q <= '0;
    end else if (ic_clear) begin
      rdata_q <= '0;
    end else if (!ic_hold && hit) begin
      rdata_q <= data_q[lookup_idx][lookup_word];
    end
  end

  // Performance counters, wrapping naturally at 2^32.
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (!fill_busy && hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign ic_rdata = rdata_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage (PCF) and a word-wide backing instruction memory. It replaces the synchronous instruction RAM read in the IF/ID boundary. It returns the instruction one cycle after the address, like the RAM it replaces, and drives `ICacheMiss` into the hazard unit so F/D stall while a line refills. It also keeps hit/miss performance counters.

## Interface
Parameters:
- `LINE_WORDS`, default 4: 32-bit words per line; power of 2, ≥2.
- `SETS`, default 16: number of lines; power of 2.
- `ADDR_W`, default 32: byte address width.

Ports:
- `CPU_CLK`  in  1  core clock; the only clock.
- `CPU_RST_N`  in  1  synchronous, active-low reset.
- `ic_req`  in  1  fetch valid this cycle.
- `ic_addr`  in  ADDR_W  fetch byte address (PCF); bits [1:0] ignored.
- `ic_hold`  in  1  hold `ic_rdata` (StallD).
- `ic_clear`  in  1  zero `ic_rdata` (FlushD).
- `ic_rdata`  out  32  instruction for the ID stage.
- `ICacheMiss`  out  1  stall request to the hazard unit.
- `mem_req`  out  1  refill word request.
- `mem_addr`  out  ADDR_W  word-aligned refill address.
- `mem_rvalid`  in  1  `mem_rdata` valid; completes the current beat.
- `mem_rdata`  in  32  refill word.
- `hit_cnt`  out  32  hit counter.
- `miss_cnt`  out  32  miss counter.

## Operation
- Address split: offset = addr[1:0] (ignored); word = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
- Storage is flop-based: valid[SETS], tag[SETS], data[SETS][LINE_WORDS]. Lookup is combinational.
- hit = `ic_req` & valid[index] & tag[index]==tag(`ic_addr`).
- FSM has two states, IDLE and FILL.
  - IDLE: on `ic_req` & !hit, capture line base address (`ic_addr` with word and offset bits zeroed), clear valid[index], write tag[index], set beat counter to 0, go to FILL, increment `miss_cnt`. On hit, increment `hit_cnt`.
  - FILL: `mem_req`=1, `mem_addr`=base + 4·beat. On `mem_rvalid`, write `mem_rdata` to data[index][beat] and increment beat. On the last beat, set valid[index] and return to IDLE.
- `ICacheMiss` = (state==FILL) | (state==IDLE & `ic_req` & !hit). It is combinational.
- `ic_rdata` register, in priority order:
  1. `ic_clear` → 0.
  2. else `ic_hold` → keep value.
  3. else `ic_req` & hit → data[index][word].
  4. else keep value.
- While in FILL, `ic_addr`, `ic_req`, `ic_hold` and `ic_clear` do not affect the refill, which always uses the captured base. `ic_clear` still zeroes `ic_rdata`.
- Counters wrap modulo 2^32.
- The re-lookup after refill is counted as a hit.

## Timing
- Reset (`CPU_RST_N`=0 at an edge):
  - All valid bits cleared; state IDLE; beat counter 0.
  - `ic_rdata`=0, `mem_req`=0, `mem_addr`=0, `hit_cnt`=0, `miss_cnt`=0.
  - Tag and data arrays are not reset.
- Hit latency: address in cycle N, `ic_rdata` valid after edge N+1. `ICacheMiss` is low in cycle N.
- Miss, with `mem_rvalid` returned in the same cycle as each `mem_req`:
  - Detected in cycle N with `ICacheMiss`=1.
  - Beats in cycles N+1 … N+LINE_WORDS.
  - IDLE and hit in cycle N+LINE_WORDS+1, with `ICacheMiss` low.
  - Data valid one edge later.
- Memory handshake: `mem_req` and `mem_addr` stay stable until `mem_rvalid`. Any number of wait cycles are allowed. `mem_rvalid` while `mem_req`=0 is ignored.
- Reset during FILL abandons the refill. The partially filled line stays invalid, and `mem_req` drops at the reset edge.
- Back-to-back misses: leaving FILL and detecting a new miss happen in different cycles. At least one IDLE cycle occurs between refills.

## Structure
- Shared package/header holds:
  - FSM state encodings `IC_IDLE` and `IC_FILL`.
  - Derived widths: `WORD_BITS`=log2(LINE_WORDS), `INDEX_BITS`=log2(SETS), `TAG_BITS`=ADDR_W-2-WORD_BITS-INDEX_BITS.
- One sub-module, `icache_refill_fsm`. It contains the state, beat counter, base address register and `mem_*` drive, and it emits array write strobes.
- The arrays, lookup, `ic_rdata` register and counters stay in `icache`.

## Test plan
- Cold miss, defaults:
  - Stimulus: `ic_req`=1, `ic_addr`=0x0000_0008; memory returns word addr·2+1 with zero wait states.
  - Required: `mem_addr` sequence 0x0, 0x4, 0x8, 0xC; `ICacheMiss` high for 5 cycles; then `ic_rdata`=0x11; `miss_cnt`=1, `hit_cnt`=1.
- Same-line hits:
  - Stimulus: after the fill, addresses 0x0, 0x4, 0xC on consecutive cycles.
  - Required: `ICacheMiss`=0 throughout; `ic_rdata` = 0x1, 0x9, 0x19 one cycle later; `hit_cnt` += 3.
- Conflict eviction:
  - Stimulus: fetch 0x100 (index 0, different tag), then 0x0.
  - Required: both miss; `mem_addr` covers 0x100–0x10C, then 0x0–0xC; `miss_cnt`=3.
- Wait states:
  - Stimulus: `mem_rvalid` only every 3rd cycle.
  - Required: `mem_addr` held stable across the wait cycles; `ICacheMiss` high for 1+3·4 cycles; correct data afterwards.
- Hold/clear:
  - Stimulus: on a hit cycle assert `ic_hold`, then `ic_clear`; also assert both together.
  - Required: value held, then 0; with both asserted, 0 (clear wins).
- Reset mid-fill:
  - Stimulus: `CPU_RST_N`=0 after beat 2 of a fill.
  - Required: `mem_req`=0 and counters 0 after the edge; re-fetching the same address misses again and performs a full 4-beat refill.
